da_sample_feeder: RTL and testbench
===================================

Name: da_sample_feeder

Overview:
- Upstream stage of the distributed-arithmetic (DA) FIR engine.
- Holds the 64-tap sample delay line and accepts one new 16-bit two's-complement sample per output.
- Drives the eight 8-bit ROM-bank addresses bit-serially, MSB slice first, and sequences the DA core with start/done.
- Captures the final 39-bit accumulator into a handshaked output register.

Parameters:
- DW, 16, sample width; equals the number of bit slices per output. The DA core's 4-bit slice counter fixes this value.
- WD_LIMIT, 255, watchdog cycle limit; used only with DA_FEED_WATCHDOG_EN.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- sample_in  in  16  new input sample x[n]
- sample_valid  in  1  sample_in valid
- sample_ready  out  1  feeder idle, can accept a sample
- A7..A0  out  8 each  ROM-bank addresses to the DA core
- da_start  out  1  one-cycle start pulse, one per bit slice
- da_done  in  1  DA core finished the current slice (single-cycle pulse)
- da_clr  out  1  one-cycle pulse to the DA core's synchronous reset; clears ACC and the slice counter
- acc_in  in  39  DA core ACC_OUT
- y_out  out  39  filtered output y[n]
- y_valid  out  1  y_out valid
- y_ready  in  1  consumer accepts y_out
- busy  out  1  high in every state except IDLE
- err  out  1  sticky watchdog error; tied 0 without the macro

Behaviour:
- Reset (asynchronous, resetn low):
  - all 64 delay registers = 0
  - A* = 0, da_start = 0, da_clr = 0
  - y_out = 0, y_valid = 0, err = 0
  - state = IDLE, slice counter = 0
  - Reset asserted mid-operation aborts immediately. No partial result is produced.
- Delay line:
  - x[t], t = 0..63; x[0] is the newest sample.
  - On accept (sample_valid & sample_ready): x[t] <= x[t-1] for t = 1..63, and x[0] <= sample_in.
- Address mapping: for bank k = 0..7 and bit j = 0..7, Ak[j] = x[8k+j][DW-1-s], where s is the slice counter (0..15).
  - Slice 0 carries the sign bits; the DA core subtracts on its first slice.
- States:
  - IDLE: sample_ready = 1. On accept, shift the delay line and go to CLR.
  - CLR: da_clr = 1 for one cycle, s <= 0, go to ISSUE.
  - ISSUE: A* drives slice s, da_start = 1 for one cycle, go to WAIT.
  - WAIT: A* held stable. On da_done: if s < 15, s <= s+1 and go to ISSUE; if s = 15, go to SETTLE.
  - SETTLE: one cycle so the DA core's ACC register updates, then go to OUT.
  - OUT:
    - If !y_valid or y_ready: y_out <= acc_in, y_valid <= 1, go to IDLE.
    - Otherwise stay in OUT (back-pressure). busy stays high.
- Output handshake:
  - y_valid stays high until a cycle with y_valid & y_ready.
  - y_valid & y_ready in the same cycle as a new capture keeps y_valid = 1 with the new data.
- Ignored inputs:
  - da_done outside WAIT is ignored.
  - sample_valid outside IDLE is not accepted; sample_ready = 0 there.
- A* outside ISSUE/WAIT holds its last value. No checker may rely on it.
- Latency for a DA core that asserts done D cycles after start: accept-to-y_valid = 1 (CLR) + 16*(D+1) + 1 (SETTLE) + 1 cycles, with no back-pressure.
- Arithmetic: the feeder does none. y_out is acc_in passed through unchanged (39 bits, two's complement).

Optional Feature:
- Macro DA_FEED_WATCHDOG_EN.
- When defined:
  - An 8-bit counter clears on entry to WAIT and increments each cycle in WAIT.
  - If it reaches WD_LIMIT without da_done: err <= 1 (sticky until resetn), pulse da_clr, go to IDLE, y_valid unchanged. The delay line keeps the shifted sample.
- When undefined: no counter; err tied 0; WAIT waits indefinitely.

Test Plan:
- Reset, feed 0x0001 → slices 0..14 drive all A* = 0x00; slice 15 drives A0 = 0x01, others 0x00. Exactly 16 da_start and 1 da_clr pulses.
- Reset, feed 0x8000 → slice 0 drives A0 = 0x01, slices 1..15 drive A0 = 0x00. Feed 0x0000 eight times → 0x8000 reaches x[8]; slice 0 drives A1 = 0x01, A0 = 0x00.
- Model DA core with D = 3 and acc_in = 39'h12_3456_789A at SETTLE → y_out = 39'h12_3456_789A, y_valid high exactly 1+64+1+1 = 67 cycles after accept.
- Hold y_ready = 0, feed two samples → second computation stalls in OUT, busy = 1, first y_out unchanged. Raise y_ready → second result captured the same cycle, y_valid stays 1.
- Pulse resetn low while in WAIT at s = 7 → all outputs 0 immediately, sample_ready = 1 after release, delay line all zero.
- With DA_FEED_WATCHDOG_EN, never assert da_done → err = 1 after 255 WAIT cycles, da_clr pulses once, state returns to IDLE. Without the macro, busy stays high and err = 0.

Source files
------------

// File: rtl/da_sample_feeder.sv
// Sample feeder for the distributed-arithmetic FIR engine: 64-tap delay line,
// bit-serial ROM-bank addressing and DA core sequencing. Optional DA_FEED_WATCHDOG_EN.
module da_sample_feeder #(
  parameter int DW       = 16,
  parameter int WD_LIMIT = 255
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [DW-1:0] sample_in,
  input  logic          sample_valid,
  output logic          sample_ready,
  output logic [7:0]    A7,
  output logic [7:0]    A6,
  output logic [7:0]    A5,
  output logic [7:0]    A4,
  output logic [7:0]    A3,
  output logic [7:0]    A2,
  output logic [7:0]    A1,
  output logic [7:0]    A0,
  output logic          da_start,
  input  logic          da_done,
  output logic          da_clr,
  input  logic [38:0]   acc_in,
  output logic [38:0]   y_out,
  output logic          y_valid,
  input  logic          y_ready,
  output logic          busy,
  output logic          err
);

  localparam int SW   = $clog2(DW);
  localparam int TAPS = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_ISSUE,
    ST_WAIT,
    ST_SETTLE,
    ST_OUT
  } state_t;

  state_t               state_q, state_d;
  logic [SW-1:0]        s_q, s_d;
  logic signed [DW-1:0] x_q [TAPS];
  logic signed [DW-1:0] x_d [TAPS];
  logic [7:0]           a_q [8];
  logic [7:0]           a_d [8];
  logic [38:0]          y_out_q, y_out_d;
  logic                 y_valid_q, y_valid_d;
  logic                 load_addr;
  logic [SW-1:0]        bit_idx;

`ifdef DA_FEED_WATCHDOG_EN
  localparam logic [7:0] WD_LAST = 8'(WD_LIMIT - 1);
  logic [7:0] wd_q, wd_d;
  logic       err_q, err_d;
  logic       wd_trip;
`endif

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    x_d       = x_q;
    a_d       = a_q;
    y_out_d   = y_out_q;
    y_valid_d = y_valid_q & ~y_ready;
    da_start  = 1'b0;
    da_clr    = 1'b0;
    load_addr = 1'b0;
    bit_idx   = '0;
`ifdef DA_FEED_WATCHDOG_EN
    wd_trip   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (sample_valid) begin
          x_d[0] = sample_in;
          for (int t = 1; t < TAPS; t++) x_d[t] = x_q[t-1];
          state_d = ST_CLR;
        end
      end
      ST_CLR: begin
        da_clr    = 1'b1;
        s_d       = '0;
        load_addr = 1'b1;
        state_d   = ST_ISSUE;
      end
      ST_ISSUE: begin
        da_start = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (da_done) begin
          if (s_q == SW'(DW - 1)) begin
            state_d = ST_SETTLE;
          end else begin
            s_d       = s_q + 1'b1;
            load_addr = 1'b1;
            state_d   = ST_ISSUE;
          end
        end
`ifdef DA_FEED_WATCHDOG_EN
        else if (wd_q == WD_LAST) begin
          // Core never answered: clear it and abandon this output.
          wd_trip = 1'b1;
          da_clr  = 1'b1;
          state_d = ST_IDLE;
        end
`endif
      end
      ST_SETTLE: state_d = ST_OUT;
      ST_OUT: begin
        if (!y_valid_q || y_ready) begin
          y_out_d   = acc_in;
          y_valid_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Slice s carries bit DW-1-s of every tap; slice 0 is the sign slice.
    if (load_addr) begin
      bit_idx = SW'(DW - 1) - s_d;
      for (int k = 0; k < 8; k++)
        for (int j = 0; j < 8; j++)
          a_d[k][j] = x_q[8*k+j][bit_idx];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      s_q       <= '0;
      y_out_q   <= '0;
      y_valid_q <= 1'b0;
      for (int t = 0; t < TAPS; t++) x_q[t] <= '0;
      for (int k = 0; k < 8; k++) a_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      y_out_q   <= y_out_d;
      y_valid_q <= y_valid_d;
      x_q       <= x_d;
      a_q       <= a_d;
    end
  end

`ifdef DA_FEED_WATCHDOG_EN
  always_comb begin
    wd_d  = (state_q == ST_WAIT) ? wd_q + 8'd1 : 8'd0;
    err_d = err_q | wd_trip;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_wd_limit;
  assign unused_wd_limit = ^8'(WD_LIMIT);
  assign err = 1'b0;
`endif

  assign sample_ready = (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign y_out        = y_out_q;
  assign y_valid      = y_valid_q;
  assign A0 = a_q[0];
  assign A1 = a_q[1];
  assign A2 = a_q[2];
  assign A3 = a_q[3];
  assign A4 = a_q[4];
  assign A5 = a_q[5];
  assign A6 = a_q[6];
  assign A7 = a_q[7];

endmodule

// File: tb/tb_da_sample_feeder.sv
// Scoreboard bench for da_sample_feeder with a behavioural DA core (done D cycles after start).
module tb_da_sample_feeder;

  localparam int D = 3;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic [7:0]  A7, A6, A5, A4, A3, A2, A1, A0;
  logic        da_start, da_done, da_clr;
  logic [38:0] acc_in = '0;
  logic [38:0] y_out;
  logic        y_valid;
  logic        y_ready = 1'b1;
  logic        busy, err;

  da_sample_feeder dut (
    .clk(clk), .resetn(resetn), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .A7(A7), .A6(A6), .A5(A5), .A4(A4), .A3(A3), .A2(A2),
    .A1(A1), .A0(A0), .da_start(da_start), .da_done(da_done), .da_clr(da_clr),
    .acc_in(acc_in), .y_out(y_out), .y_valid(y_valid), .y_ready(y_ready),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  wire [63:0] a_bus = {A7, A6, A5, A4, A3, A2, A1, A0};

  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          start_cnt = 0;
  int          clr_cnt = 0;
  int          acc_cyc = 0;
  int          rise_cyc = 0;
  logic        hang = 1'b0;
  logic [63:0] slice_log [16];
  logic [38:0] sb_q [$];
  logic [38:0] v1, v2;
  logic [63:0] acc_or;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural DA core
  initial begin
    da_done = 1'b0;
    forever begin
      @(negedge clk);
      if (da_start && !hang) begin
        repeat (D) @(posedge clk);
        #1 da_done = 1'b1;
        @(posedge clk);
        #1 da_done = 1'b0;
      end
    end
  end

  // Slice / clear logger
  initial begin
    forever begin
      @(negedge clk);
      if (resetn && da_start) begin
        if (start_cnt < 16) slice_log[start_cnt] = a_bus;
        start_cnt++;
      end
      if (resetn && da_clr) clr_cnt++;
    end
  end

  // Output scoreboard
  initial begin
    logic yv_prev;
    logic [38:0] exp_y;
    yv_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (y_valid && !yv_prev) rise_cyc = cyc;
      if (y_valid && y_ready) begin
        if (sb_q.size() == 0) check_val("y_unexpected", 64'(y_out), 64'h0);
        else begin
          exp_y = sb_q.pop_front();
          check_val("y_out", 64'(y_out), 64'(exp_y));
        end
      end
      yv_prev = y_valid;
    end
  end

  task automatic do_reset();
    sample_valid = 1'b0;
    y_ready = 1'b1;
    hang = 1'b0;
    resetn = 1'b0;
    sb_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic feed(input logic [15:0] s, input logic [38:0] acc, input logic push);
    int n;
    n = 0;
    while (!sample_ready && n < 2000) begin @(negedge clk); n++; end
    check_val("feed_ready", 64'(sample_ready), 64'h1);
    start_cnt = 0;
    clr_cnt = 0;
    sample_in = s;
    acc_in = acc;
    sample_valid = 1'b1;
    if (push) sb_q.push_back(acc);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    sample_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!(sb_q.size() == 0 && sample_ready) && n < 2000) begin @(negedge clk); n++; end
    check_val("drain", 64'(sb_q.size() == 0 && sample_ready), 64'h1);
  endtask

  initial begin
    do_reset();
    check_val("rst_ready", 64'(sample_ready), 64'h1);
    check_val("rst_busy", 64'(busy), 64'h0);
    check_val("rst_yvalid", 64'(y_valid), 64'h0);
    check_val("rst_yout", 64'(y_out), 64'h0);
    check_val("rst_abus", a_bus, 64'h0);
    check_val("rst_start_clr", 64'({da_start, da_clr}), 64'h0);
    check_val("rst_err", 64'(err), 64'h0);

    // 0x0001: only the last (LSB) slice sees the 1 on A0
    feed(16'h0001, 39'h12_3456_789A, 1'b1);
    drain();
    check_val("p1_starts", 64'(start_cnt), 64'd16);
    check_val("p1_clrs", 64'(clr_cnt), 64'd1);
    acc_or = '0;
    for (int i = 0; i < 15; i++) acc_or |= slice_log[i];
    check_val("p1_slices0_14", acc_or, 64'h0);
    check_val("p1_slice15", slice_log[15], 64'h01);
    check_val("p1_latency", 64'(rise_cyc - acc_cyc), 64'd67);

    // 0x8000: sign slice only, then walk it to x[8]
    do_reset();
    feed(16'h8000, 39'h7F_0000_0001, 1'b1);
    drain();
    check_val("p2_slice0", slice_log[0], 64'h01);
    acc_or = '0;
    for (int i = 1; i < 16; i++) acc_or |= slice_log[i];
    check_val("p2_slices1_15", acc_or, 64'h0);
    for (int i = 0; i < 8; i++) begin
      feed(16'h0000, 39'({$urandom, $urandom}), 1'b1);
      drain();
    end
    check_val("p2_x8_slice0", slice_log[0], 64'h0100);
    check_val("p2_x8_latency", 64'(rise_cyc - acc_cyc), 64'd67);

    // Back-pressure: second result waits in OUT
    do_reset();
    y_ready = 1'b0;
    v1 = 39'h55_AAAA_0F0F;
    v2 = 39'h2A_1234_F00D;
    feed(16'h1234, v1, 1'b1);
    feed(16'hBEEF, v2, 1'b1);
    repeat (100) @(negedge clk);
    check_val("bp_busy", 64'(busy), 64'h1);
    check_val("bp_ready", 64'(sample_ready), 64'h0);
    check_val("bp_yvalid", 64'(y_valid), 64'h1);
    check_val("bp_yout_first", 64'(y_out), 64'(v1));
    @(posedge clk);
    #1 y_ready = 1'b1;
    @(posedge clk);
    #1;
    check_val("bp_yvalid_kept", 64'(y_valid), 64'h1);
    check_val("bp_yout_second", 64'(y_out), 64'(v2));
    check_val("bp_idle", 64'(busy), 64'h0);
    drain();

    // Reset while waiting on slice 7
    feed(16'h7FFF, 39'h1, 1'b1);
    begin
      int n;
      n = 0;
      while (start_cnt < 8 && n < 500) begin @(negedge clk); #1; n++; end
      check_val("rw_reach_s7", 64'(start_cnt), 64'd8);
    end
    check_val("rw_abus_live", a_bus, 64'h01);
    @(posedge clk);
    #2 resetn = 1'b0;
    sb_q.delete();
    #1;
    check_val("rw_abus", a_bus, 64'h0);
    check_val("rw_start_clr", 64'({da_start, da_clr}), 64'h0);
    check_val("rw_yout", 64'(y_out), 64'h0);
    check_val("rw_yvalid", 64'(y_valid), 64'h0);
    check_val("rw_busy_err", 64'({busy, err}), 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    check_val("rw_ready", 64'(sample_ready), 64'h1);
    feed(16'h0000, 39'h3C_0000_00C3, 1'b1);
    drain();
    acc_or = '0;
    for (int i = 0; i < 16; i++) acc_or |= slice_log[i];
    check_val("rw_line_zero", acc_or, 64'h0);

    // DA core never answers
    hang = 1'b1;
    feed(16'h4321, 39'h0, 1'b0);
`ifdef DA_FEED_WATCHDOG_EN
    begin
      int n;
      n = 0;
      while (!err && n < 400) begin @(negedge clk); n++; end
    end
    check_val("wd_err", 64'(err), 64'h1);
    @(negedge clk);
    check_val("wd_idle", 64'(busy), 64'h0);
    check_val("wd_clrs", 64'(clr_cnt), 64'd2);
    check_val("wd_yvalid", 64'(y_valid), 64'h0);
`else
    repeat (400) @(negedge clk);
    check_val("nowd_busy", 64'(busy), 64'h1);
    check_val("nowd_err", 64'(err), 64'h0);
`endif
    do_reset();
    check_val("sb_empty", 64'(sb_q.size()), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
